alu_status_unit: RTL

- Sits directly downstream of the 32-bit ALU in the single-cycle MIPS-lite datapath.
- Registers the ALU's zero/negative/overflow status outputs into a flag register.
- Evaluates branch conditions (BEQ/BNE/BLEZ-family/BVS) against the stored flags for the PC-select logic.
- Keeps a sticky overflow bit and a saturating overflow counter.
- Raises an overflow trap request that is held by a req/ack handshake until the control unit acknowledges it.

---
 rtl/alu_status_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_status_unit.sv
// alu_status_unit: captures ALU Z/N/V status after each flag-setting
// instruction, evaluates branch conditions for PC selection, tracks overflow
// history (sticky bit and saturating counter) and raises an overflow trap
// request that stays asserted until the control unit acknowledges it.
module alu_status_unit #(
  parameter int CNT_W  = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flag_we,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             v_in,
  input  logic             cond_valid,
  input  logic [2:0]       cond,
  output logic             take_branch,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag,
  output logic             v_sticky,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             trap_en,
  output logic             trap_req,
  input  logic             trap_ack
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } trap_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  trap_state_t state;
  logic        ovf_evt;
  logic        trap_arm;
  logic        use_in;
  logic        src_z;
  logic        src_n;
  logic        src_v;
  logic        cond_true;

  // An overflow only counts when the instruction actually writes the flags.
  assign ovf_evt  = flag_we & v_in;
  assign trap_arm = ovf_evt & trap_en;

  // Flag register: load all three status bits together on a flag write.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_flag <= 1'b0;
      n_flag <= 1'b0;
      v_flag <= 1'b0;
    end else if (flag_we) begin
      z_flag <= z_in;
      n_flag <= n_in;
      v_flag <= v_in;
    end
  end

  // Sticky overflow: a new overflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_sticky <= 1'b0;
    end else if (ovf_evt) begin
      v_sticky <= 1'b1;
    end else if (sticky_clr) begin
      v_sticky <= 1'b0;
    end
  end

  // Overflow event counter: saturates at all-ones, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (ovf_evt && (ovf_count != CNT_MAX)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  // Trap handshake FSM: at most one pending trap; a new armed overflow
  // arriving with the ack keeps the request up instead of dropping it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      trap_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_arm) begin
            state    <= PEND;
            trap_req <= 1'b1;
          end
        end
        PEND: begin
          if (trap_ack && !trap_arm) begin
            state    <= IDLE;
            trap_req <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          trap_req <= 1'b0;
        end
      endcase
    end
  end

  // Branch flag source: optionally forward the flags being written this cycle.
  always_comb begin
    use_in = BYPASS && flag_we;
    src_z  = use_in ? z_in : z_flag;
    src_n  = use_in ? n_in : n_flag;
    src_v  = use_in ? v_in : v_flag;
  end

  // Branch condition decode, gated by cond_valid.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = 1'b0;
      3'b001:  cond_true = 1'b1;
      3'b010:  cond_true = src_z;
      3'b011:  cond_true = ~src_z;
      3'b100:  cond_true = src_z | src_n;
      3'b101:  cond_true = ~src_z & ~src_n;
      3'b110:  cond_true = src_n;
      3'b111:  cond_true = src_v;
      default: cond_true = 1'b0;
    endcase
    take_branch = cond_valid & cond_true;
  end

endmodule
